// File: rtl/tcdm_bank_responder.sv
// Single-bank TCDM slave: round-robin arbitration of MP request ports onto one
// word-organised bank, with a registered one-cycle response per granted access.
module tcdm_bank_responder #(
  parameter int          MP        = 4,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid,
  input  logic                 stall_i,
  output logic                 err_o,
  output logic [31:0]          access_cnt_o
);

  localparam int          PW    = (MP > 1) ? $clog2(MP) : 1;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

  // Handshake: a port's access is accepted in the cycle tcdm_req and tcdm_gnt
  // are both high; its response arrives as tcdm_r_valid exactly one cycle later.

  logic [PW-1:0] rr_q;
  logic [PW-1:0] win;
  logic          found;
  logic          grant;
  logic [31:0]   sel_add;
  logic [31:0]   sel_data;
  logic [3:0]    sel_be;
  logic          sel_wen;
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] word;

  logic [31:0] mem [DEPTH];

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < MP; i++) begin
      if (!found && tcdm_req[PW'((int'(rr_q) + i) % MP)]) begin
        found = 1'b1;
        win   = PW'((int'(rr_q) + i) % MP);
      end
    end
    grant    = found && !stall_i;
    tcdm_gnt = '0;
    if (grant) tcdm_gnt[win] = 1'b1;
    sel_add  = tcdm_add[win];
    sel_data = tcdm_data[win];
    sel_be   = tcdm_be[win];
    sel_wen  = tcdm_wen[win];
    // Unsigned subtraction makes addresses below the base wrap to huge offsets.
    off      = sel_add - BASE_ADDR;
    in_range = {1'b0, off} < LIMIT;
    word     = off[2 +: AW];
  end

  // Bank contents are deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (grant && !sel_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) mem[word][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcdm_r_valid <= '0;
      tcdm_r_data  <= '0;
      err_o        <= 1'b0;
      access_cnt_o <= '0;
      rr_q         <= '0;
    end else begin
      tcdm_r_valid <= tcdm_gnt;
      err_o        <= grant && !in_range;
      if (grant) begin
        tcdm_r_data[win] <= (sel_wen && in_range) ? mem[word] : 32'h0;
        if (access_cnt_o != 32'hFFFF_FFFF) access_cnt_o <= access_cnt_o + 32'd1;
        rr_q <= PW'((int'(win) + 1) % MP);
      end
    end
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder: write/read, byte enables, stall,
// out-of-range decode, reset mid-access and round-robin order.
module tb_tcdm_bank_responder;

  localparam logic [31:0] B = 32'h1000_0000;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [3:0][31:0] add;
  logic [3:0]       wen;
  logic [3:0][3:0]  be;
  logic [3:0][31:0] data;
  logic [3:0][31:0] r_data;
  logic [3:0]       r_valid;
  logic             stall;
  logic             err;
  logic [31:0]      cnt;

  int passed = 0;
  int total  = 0;

  tcdm_bank_responder #(.MP(4), .DEPTH(1024), .BASE_ADDR(B)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .tcdm_req     (req),
    .tcdm_gnt     (gnt),
    .tcdm_add     (add),
    .tcdm_wen     (wen),
    .tcdm_be      (be),
    .tcdm_data    (data),
    .tcdm_r_data  (r_data),
    .tcdm_r_valid (r_valid),
    .stall_i      (stall),
    .err_o        (err),
    .access_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One single-port access: request now, check grant, then check the response.
  task automatic access(input int p, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
    logic [3:0] eg;
    eg     = '0;
    eg[p]  = 1'b1;
    req    = '0;
    req[p] = 1'b1;
    wen[p] = w;
    add[p] = a;
    be[p]  = b;
    data[p] = d;
    #1 chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk); #1;
    req[p] = 1'b0;
    chk({tag, "_rvalid"}, 32'(r_valid), 32'(eg));
    chk({tag, "_rdata"}, r_data[p], exp_rd);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [3:0] eg;
    rst_ni = 1'b0;
    req = '0; add = '0; wen = '0; be = '0; data = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(r_valid), 32'h0);
    for (int p = 0; p < 4; p++) chk("rst_rdata", r_data[p], 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // single port write then read
    access(0, 1'b0, B + 32'd8, 4'hF, 32'hA5A5_5A5A, 32'h0, 1'b0, "t1_wr");
    access(0, 1'b1, B + 32'd8, 4'h0, 32'h0, 32'hA5A5_5A5A, 1'b0, "t1_rd");
    chk("t1_cnt", cnt, 32'd2);

    // byte enables
    access(0, 1'b0, B + 32'd12, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, "be_full");
    access(0, 1'b0, B + 32'd12, 4'b0101, 32'h1122_3344, 32'h0, 1'b0, "be_part");
    access(0, 1'b1, B + 32'd12, 4'h0, 32'h0, 32'hFF22_FF44, 1'b0, "be_rd");
    chk("be_cnt", cnt, 32'd5);

    // stall: port1 granted just before, its response lands during the stall
    req = '0; req[1] = 1'b1; wen[1] = 1'b1; add[1] = B + 32'd12;
    #1 chk("st_pre_gnt", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    req[2] = 1'b1; wen[2] = 1'b1; add[2] = B + 32'd8;
    stall = 1'b1;
    #1 chk("st_gnt0", 32'(gnt), 32'h0);
    chk("st_inflight_rv", 32'(r_valid), 32'h2);
    chk("st_inflight_rd", r_data[1], 32'hFF22_FF44);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("st_gnt", 32'(gnt), 32'h0);
      chk("st_rv", 32'(r_valid), 32'h0);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    #1 chk("st_rel_gnt2", 32'(gnt), 32'h4);
    @(posedge clk); #1;
    req[2] = 1'b0;
    chk("st_rel_rv2", 32'(r_valid), 32'h4);
    chk("st_rel_rd2", r_data[2], 32'hA5A5_5A5A);
    #1 chk("st_rel_gnt1", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("st_rel_rv1", 32'(r_valid), 32'h2);
    chk("st_rel_rd1", r_data[1], 32'hFF22_FF44);
    chk("st_cnt", cnt, 32'd8);

    // out of range: both ends, plus words an aliasing decode would hit
    access(3, 1'b0, B, 4'hF, 32'h0000_1111, 32'h0, 1'b0, "oor_w0");
    access(3, 1'b0, B + 32'hFFC, 4'hF, 32'h2222_0000, 32'h0, 1'b0, "oor_wlast");
    access(3, 1'b1, B + 32'd8, 4'h0, 32'h0, 32'hA5A5_5A5A, 1'b0, "oor_rd_in");
    access(3, 1'b1, B + 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, "oor_rd_hi");
    access(3, 1'b0, B + 32'h1000, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1, "oor_wr_hi");
    access(3, 1'b0, B - 32'd4, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1, "oor_wr_lo");
    access(3, 1'b1, B - 32'd4, 4'h0, 32'h0, 32'h0, 1'b1, "oor_rd_lo");
    access(3, 1'b1, B, 4'h0, 32'h0, 32'h0000_1111, 1'b0, "oor_chk0");
    access(3, 1'b1, B + 32'hFFC, 4'h0, 32'h0, 32'h2222_0000, 1'b0, "oor_chklast");
    chk("oor_cnt", cnt, 32'd17);

    // reset the cycle after a grant
    req = '0; req[1] = 1'b1; wen[1] = 1'b1; add[1] = B + 32'd8;
    #1 chk("rm_gnt", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    req = '0;
    chk("rm_rv_pre", 32'(r_valid), 32'h2);
    rst_ni = 1'b0;
    #1 chk("rm_rv", 32'(r_valid), 32'h0);
    chk("rm_cnt", cnt, 32'h0);
    chk("rm_rd", r_data[1], 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // round robin from reset, all ports requesting continuously
    req = 4'hF; wen = 4'hF;
    for (int p = 0; p < 4; p++) add[p] = B + 32'd8;
    for (int c = 0; c < 8; c++) begin
      eg = '0;
      eg[c % 4] = 1'b1;
      #1 chk("rr_gnt", 32'(gnt), 32'(eg));
      @(posedge clk); #1;
      chk("rr_rv", 32'(r_valid), 32'(eg));
      chk("rr_rd", r_data[c % 4], 32'hA5A5_5A5A);
    end
    req = '0;
    #1 chk("rr_idle_gnt", 32'(gnt), 32'h0);
    chk("rr_cnt", cnt, 32'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_responder.md
# tcdm_bank_responder

Single-bank TCDM slave that answers the accelerator-side TCDM master ports of an HWPE wrapper. It arbitrates `MP` request ports onto one word-organised memory bank with round-robin priority and a one-cycle response pipeline. It serves as the memory end of the HWPE TCDM protocol in standalone accelerator benches and in small cluster configurations.

## Interface
Parameters:
- `MP`, 4, number of TCDM slave ports
- `DEPTH`, 1024, bank size in 32-bit words, power of two ≥ 2
- `BASE_ADDR`, 32'h1000_0000, byte address of word 0, `DEPTH*4`-aligned

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `tcdm_req` in [MP]: request per port
- `tcdm_gnt` out [MP]: grant, combinational, same cycle as the request
- `tcdm_add` in [MP][32]: byte address
- `tcdm_wen` in [MP]: 1 = read, 0 = write
- `tcdm_be` in [MP][4]: byte enables, writes only
- `tcdm_data` in [MP][32]: write data
- `tcdm_r_data` out [MP][32]: response data
- `tcdm_r_valid` out [MP]: response valid
- `stall_i` in 1: when 1, no grant is issued (bench back-pressure)
- `err_o` out 1: one-cycle pulse when a granted access is out of range
- `access_cnt_o` out 32: saturating count of granted accesses

## Operation
- Arbitration: round-robin pointer `rr_q` (log2 MP bits, reset 0). Search order is `rr_q, rr_q+1, …` modulo MP. The first requesting port wins. At most one `tcdm_gnt` bit is high per cycle.
- Grant: `gnt[k] = winner==k && !stall_i`. The pointer advances to `winner+1` mod MP only on a grant. With `stall_i=1` the pointer holds.
- A requester holds `req`, `add`, `wen`, `be`, and `data` until granted. The block does not depend on this, but the test bench checks it.
- Decode: `off = add - BASE_ADDR` (32-bit unsigned). The access is in range iff `off < DEPTH*4`. The word index is `off[2 +: log2(DEPTH)]`, and `add[1:0]` is ignored.
- Write, in range: byte lane `b` is updated iff `be[b]`. `be=0` is a legal no-op write.
- Write, out of range: the write is dropped. It is still granted and still gets a response. `err_o` fires.
- Read, in range: the response returns the word contents as of the grant edge. A write granted in cycle N is visible to a read granted in cycle N+1.
- Read, out of range: returns 32'h0 and `err_o` fires.
- Bank contents are not reset. Reading an unwritten word returns X, and test benches must write before reading.
- Response path: on a grant to port k, `r_valid[k]` is registered high for exactly the next cycle. `r_data[k]` is registered as the read data for reads, or 32'h0 for writes. Every granted access, read or write, produces exactly one response.
- Non-granted ports have `r_valid=0` and `r_data` holding its last value.
- `access_cnt_o` increments on every grant and saturates at 32'hFFFF_FFFF.

## Timing
- Reset values: `tcdm_r_valid=0`, `tcdm_r_data=0` on all ports, `err_o=0`, `access_cnt_o=0`, `rr_q=0`. `tcdm_gnt` is combinational and is 0 while `tcdm_req=0`.
- Grant latency is 0 cycles from `req`. Response latency is exactly 1 cycle after the grant edge. `err_o` is aligned with the corresponding `r_valid`.
- Throughput is one access per cycle across all ports. Back-to-back grants to the same port give back-to-back `r_valid`.
- `stall_i` is sampled combinationally. A response already in flight is still delivered while `stall_i=1`.
- Asynchronous reset mid-operation:
  - In-flight responses are discarded (`r_valid` drops immediately).
  - Counters and pointer clear.
  - The bank is unchanged except for a write clocked on the same edge, which is undefined.
- Simultaneous write and read requests to the same address on different ports are serialised by arbitration. The later-granted access sees the earlier one's effect.

## Test plan
- Single port, write then read: port0 writes 32'hA5A5_5A5A to `BASE_ADDR+8` with `be=4'hF`, then reads it. Expected: gnt in the request cycle, r_valid 1 cycle later, r_data=32'h0 for the write and 32'hA5A5_5A5A for the read. `access_cnt_o=2`.
- Byte enables: write 32'hFFFF_FFFF, then write 32'h1122_3344 with `be=4'b0101`, then read. Expected r_data=32'hFF22_FF44.
- Round-robin: all 4 ports request continuously from reset. Expected grants in order 0,1,2,3,0,1…, with each r_valid one cycle after its grant.
- Stall: assert `stall_i` for 3 cycles with port2 requesting. Expected: no grants and the pointer held. On release port2 is granted first, and an in-flight response during the stall is still delivered.
- Out of range: read and write `BASE_ADDR+DEPTH*4` and `BASE_ADDR-4`. Expected: granted, `err_o` pulses with r_valid, read returns 32'h0, and no in-range word changes.
- Reset mid-access: assert `rst_ni=0` the cycle after a grant. Expected: r_valid=0 immediately, `access_cnt_o=0`, and the next request after reset is granted to port0 first.
